complex_sum: RTL and testbench



---
 rtl/complex_sum.sv | 87 ++++++++
 tb/tb_complex_sum.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/complex_sum.sv
// Two-lane packed complex adder/subtractor: {RE, IM} lanes, each signed LANE_W bits.
// The operands are registered first, then the lane results, so the latency is two clocks.
module complex_sum #(
  parameter int LANE_W   = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                sub,
  input  logic [2*LANE_W-1:0] sum_A,
  input  logic [2*LANE_W-1:0] sum_B,
  output logic [2*LANE_W-1:0] sum_out,
  output logic                done,
  output logic [1:0]          ovf
);

  logic [2*LANE_W-1:0] a_reg;
  logic [2*LANE_W-1:0] b_reg;
  logic                sub_reg;
  logic                valid1_reg;

  logic [2*LANE_W-1:0] sum_out_reg;
  logic                done_reg;
  logic [1:0]          ovf_reg;

  logic [2*LANE_W-1:0] sum_next;
  logic [1:0]          ovf_next;

  // Lane 0 is IM (low half) and lane 1 is RE (high half).
  // Each lane is computed one bit wider, so no carry or borrow crosses between lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [LANE_W:0]   a_ext;
      logic [LANE_W:0]   b_ext;
      logic [LANE_W:0]   wide;
      logic              lane_ovf;
      logic [LANE_W-1:0] lane_res;

      always_comb begin
        a_ext    = {a_reg[gi*LANE_W+LANE_W-1], a_reg[gi*LANE_W +: LANE_W]};
        b_ext    = {b_reg[gi*LANE_W+LANE_W-1], b_reg[gi*LANE_W +: LANE_W]};
        wide     = sub_reg ? (a_ext - b_ext) : (a_ext + b_ext);
        lane_ovf = wide[LANE_W] ^ wide[LANE_W-1];
        lane_res = wide[LANE_W-1:0];
        // The wide sign bit tells the true direction of the overflow.
        if (lane_ovf && SATURATE) begin
          lane_res = wide[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                  : {1'b0, {(LANE_W-1){1'b1}}};
        end
      end

      assign sum_next[gi*LANE_W +: LANE_W] = lane_res;
      assign ovf_next[gi]                  = lane_ovf;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg       <= '0;
      b_reg       <= '0;
      sub_reg     <= 1'b0;
      valid1_reg  <= 1'b0;
      sum_out_reg <= '0;
      done_reg    <= 1'b0;
      ovf_reg     <= 2'b00;
    end else begin
      valid1_reg <= start;
      if (start) begin
        a_reg   <= sum_A;
        b_reg   <= sum_B;
        sub_reg <= sub;
      end
      done_reg <= valid1_reg;
      if (valid1_reg) begin
        sum_out_reg <= sum_next;
        ovf_reg     <= ovf_next;
      end
    end
  end

  assign sum_out = sum_out_reg;
  assign done    = done_reg;
  assign ovf     = ovf_reg;

endmodule

// File: tb/tb_complex_sum.sv
// Directed bench for complex_sum: a saturating and a wrapping instance share the same stimulus.
module tb_complex_sum;

  logic        clock;
  logic        reset;
  logic        start;
  logic        sub;
  logic [63:0] sum_A;
  logic [63:0] sum_B;
  logic [63:0] sum_out_sat;
  logic [63:0] sum_out_wrap;
  logic        done_sat;
  logic        done_wrap;
  logic [1:0]  ovf_sat;
  logic [1:0]  ovf_wrap;

  int tests;
  int fails;

  complex_sum #(.LANE_W(32), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .sub(sub),
    .sum_A(sum_A), .sum_B(sum_B),
    .sum_out(sum_out_sat), .done(done_sat), .ovf(ovf_sat)
  );

  complex_sum #(.LANE_W(32), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .sub(sub),
    .sum_A(sum_A), .sum_B(sum_B),
    .sum_out(sum_out_wrap), .done(done_wrap), .ovf(ovf_wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] exp_sat;
    logic [63:0] exp_wrap;
    logic [1:0]  exp_ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic d, input logic [63:0] es,
                           input logic [63:0] ew, input logic [1:0] eo);
    check({name, " done_sat"}, {63'd0, done_sat}, {63'd0, d});
    check({name, " done_wrap"}, {63'd0, done_wrap}, {63'd0, d});
    check({name, " sum_sat"}, sum_out_sat, es);
    check({name, " sum_wrap"}, sum_out_wrap, ew);
    check({name, " ovf_sat"}, {62'd0, ovf_sat}, {62'd0, eo});
    check({name, " ovf_wrap"}, {62'd0, ovf_wrap}, {62'd0, eo});
    $display("[TB] %s: done=%0b sat=%h wrap=%h ovf=%b", name, done_sat, sum_out_sat, sum_out_wrap, ovf_sat);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    vecs[0] = '{64'h00000003_00000005, 64'h00000004_FFFFFFFE, 1'b0,
                64'h00000007_00000003, 64'h00000007_00000003, 2'b00};
    vecs[1] = '{64'h0000000A_00000001, 64'h00000003_00000002, 1'b1,
                64'h00000007_FFFFFFFF, 64'h00000007_FFFFFFFF, 2'b00};
    vecs[2] = '{64'h7FFFFFFF_80000000, 64'h00000001_FFFFFFFF, 1'b0,
                64'h7FFFFFFF_80000000, 64'h80000000_7FFFFFFF, 2'b11};
    vecs[3] = '{64'h00000000_FFFFFFFF, 64'h80000000_80000000, 1'b1,
                64'h7FFFFFFF_7FFFFFFF, 64'h80000000_7FFFFFFF, 2'b10};
    vecs[4] = '{64'h80000000_00000005, 64'h00000001_00000007, 1'b1,
                64'h80000000_FFFFFFFE, 64'h7FFFFFFF_FFFFFFFE, 2'b10};
    vecs[5] = '{64'h00000000_FFFFFFFF, 64'h00000000_00000001, 1'b0,
                64'h00000000_00000000, 64'h00000000_00000000, 2'b00};
    vecs[6] = '{64'hFFFFFFFF_FFFFFFFE, 64'hFFFFFFFF_FFFFFFFF, 1'b0,
                64'hFFFFFFFE_FFFFFFFD, 64'hFFFFFFFE_FFFFFFFD, 2'b00};

    reset = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    sum_A = '0;
    sum_B = '0;
    tick();
    tick();
    check_all("reset", 1'b0, 64'd0, 64'd0, 2'b00);
    reset = 1'b0;
    tick();

    // Single operations: start for one cycle, done two edges later, then one idle cycle.
    for (int i = 0; i < 7; i++) begin
      sum_A = vecs[i].a;
      sum_B = vecs[i].b;
      sub   = vecs[i].sub;
      start = 1'b1;
      tick();
      start = 1'b0;
      sum_A = '0;
      sum_B = '0;
      sub   = 1'b0;
      check_all($sformatf("vec%0d early", i), 1'b0,
                (i == 0) ? 64'd0 : vecs[i-1].exp_sat,
                (i == 0) ? 64'd0 : vecs[i-1].exp_wrap,
                (i == 0) ? 2'b00 : vecs[i-1].exp_ovf);
      tick();
      check_all($sformatf("vec%0d", i), 1'b1, vecs[i].exp_sat, vecs[i].exp_wrap, vecs[i].exp_ovf);
      tick();
      check_all($sformatf("vec%0d hold", i), 1'b0, vecs[i].exp_sat, vecs[i].exp_wrap, vecs[i].exp_ovf);
    end

    // Three back-to-back starts: the done pulses arrive on consecutive cycles, in order.
    for (int k = 0; k < 3; k++) begin
      sum_A = {32'(k + 1), 32'(k + 1)};
      sum_B = {32'd1, 32'd1};
      sub   = 1'b0;
      start = 1'b1;
      tick();
      if (k >= 1) begin
        check_all($sformatf("pipe%0d", k - 1), 1'b1, {32'(k + 1), 32'(k + 1)},
                  {32'(k + 1), 32'(k + 1)}, 2'b00);
      end else begin
        check_all("pipe idle", 1'b0, vecs[6].exp_sat, vecs[6].exp_wrap, 2'b00);
      end
    end
    start = 1'b0;
    tick();
    check_all("pipe2", 1'b1, 64'h00000004_00000004, 64'h00000004_00000004, 2'b00);
    tick();
    check_all("pipe hold", 1'b0, 64'h00000004_00000004, 64'h00000004_00000004, 2'b00);

    // Reset one edge after start: the operation in flight must never complete.
    sum_A = 64'h00000010_00000010;
    sum_B = 64'h00000001_00000001;
    start = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("midflight reset", 1'b0, 64'd0, 64'd0, 2'b00);
    tick();
    check_all("midflight after", 1'b0, 64'd0, 64'd0, 2'b00);

    // A two-cycle reset while the pipeline is busy.
    sum_A = 64'h7FFFFFFF_00000001;
    sum_B = 64'h00000001_00000001;
    start = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_all("busy reset", 1'b0, 64'd0, 64'd0, 2'b00);
    tick();
    reset = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("busy post%0d", k), 1'b0, 64'd0, 64'd0, 2'b00);
    end

    // start together with reset: reset wins and nothing is captured.
    sum_A = 64'h00000005_00000005;
    sum_B = 64'h00000005_00000005;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("start+reset %0d", k), 1'b0, 64'd0, 64'd0, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
